// File: rtl/scale_table_arb.sv
// scale_table_arb
// Runtime-writable tone-word table shared by NUM_CH voice channels.
// After reset the table is cleared one entry per cycle (INIT), then the
// single storage port is shared between host writes (highest priority)
// and round-robin read grants. Each granted read returns a registered
// tone word, shifted right by the channel's octave shift.

module scale_table_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_CH-1:0]              rd_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_CH*2-1:0]            rd_shift,
  output logic [NUM_CH-1:0]              rd_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
  output logic                           init_done,
  output logic [ADDR_WIDTH-1:0]          last_address
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Control state
  logic [0:0]                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]       clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]            rr_q, rr_d;
  logic [NUM_CH-1:0]           rd_valid_q, rd_valid_d;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Tone-word storage
  logic [DATA_WIDTH-1:0]       tbl_q [DEPTH];

  // Storage write port, shared by the INIT clear and host writes
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0]       mem_wdata;

  // Arbitration results
  logic [NUM_CH-1:0]           eligible;
  logic                        grant_vld;
  logic [PTR_W-1:0]            grant_idx;
  logic [ADDR_WIDTH-1:0]       grant_addr;
  logic [1:0]                  grant_shift;
  logic [DATA_WIDTH-1:0]       grant_word;

  // Round-robin search: a channel granted last cycle is masked so that its
  // still-high request (held until it sees rd_valid) is not double-served.
  // Scanning downward leaves the first eligible channel from rr_q as winner.
  always_comb begin
    int idx;
    idx       = 0;
    eligible  = rd_req & ~rd_valid_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    if ((state_q == ST_RUN) && !wr_en) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = (int'(rr_q) + k) % NUM_CH;
        if (eligible[idx]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
  end

  // INIT walks the clear counter over every entry; RUN forwards host writes.
  // A write strobe seen during INIT is simply ignored.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = wr_en;
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Read datapath: fetch and shift the granted channel's word, pulse its
  // valid, hold every other channel's data, and advance the pointer.
  always_comb begin
    grant_addr  = rd_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    grant_shift = rd_shift[grant_idx*2 +: 2];
    grant_word  = tbl_q[grant_addr] >> grant_shift;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    rr_d        = rr_q;
    if (grant_vld) begin
      rd_valid_d[grant_idx]                           = 1'b1;
      rd_data_d[grant_idx*DATA_WIDTH +: DATA_WIDTH]   = grant_word;
      if (int'(grant_idx) == NUM_CH - 1) begin
        rr_d = '0;
      end else begin
        rr_d = grant_idx + 1'b1;
      end
    end
  end

  // Control and output registers; reset discards any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      rr_q       <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rr_q       <= rr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Table storage write; no access happens in a reset cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      tbl_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign init_done    = (state_q == ST_RUN);
  assign last_address = {ADDR_WIDTH{1'b1}};

endmodule
